// File: rtl/epsilon_pkg.sv
// Shared types and helpers for the epsilon conditioner: FSM state encoding,
// von Neumann pair encodings and derived width helpers.
package epsilon_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_DRAIN   = 2'd2
  } state_e;

  // Pair is packed as {first_sample, second_sample}.
  localparam logic [1:0] VN_PAIR_01 = 2'b01;
  localparam logic [1:0] VN_PAIR_10 = 2'b10;

  function automatic int cnt_width(input int block_len);
    return $clog2(block_len + 1);
  endfunction

  function automatic logic vn_emits(input logic [1:0] pair);
    logic r;
    case (pair)
      VN_PAIR_01: r = 1'b1;
      VN_PAIR_10: r = 1'b1;
      default:    r = 1'b0;
    endcase
    return r;
  endfunction

  function automatic logic vn_bit(input logic [1:0] pair);
    return (pair == VN_PAIR_10);
  endfunction

endpackage

// File: rtl/epsilon_fifo.sv
// First-word-fall-through FIFO carrying one data bit plus a last flag per entry.
// A simultaneous push and pop on a full FIFO is accepted.
module epsilon_fifo
  import epsilon_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic push_i,
  input  logic push_dat_i,
  input  logic push_last_i,
  input  logic pop_i,
  output logic dat_o,
  output logic last_o,
  output logic vld_o,
  output logic full_o,
  output logic empty_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [DEPTH-1:0] dat_mem_q;
  logic [DEPTH-1:0] last_mem_q;
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [CW-1:0]    cnt_q;
  logic             wr_en_s;
  logic             rd_en_s;

  assign empty_o = (cnt_q == CW'(0));
  assign full_o  = (cnt_q == CW'(DEPTH));
  assign wr_en_s = push_i & (~full_o | pop_i);
  assign rd_en_s = pop_i & ~empty_o;

  // Head is gated so an empty FIFO presents 0 rather than a stale entry.
  assign vld_o  = ~empty_o;
  assign dat_o  = ~empty_o & dat_mem_q[rd_ptr_q];
  assign last_o = ~empty_o & last_mem_q[rd_ptr_q];

  always_ff @(posedge clk) begin
    if (rst) begin
      dat_mem_q  <= '0;
      last_mem_q <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      cnt_q      <= '0;
    end else begin
      if (wr_en_s) begin
        dat_mem_q[wr_ptr_q]  <= push_dat_i;
        last_mem_q[wr_ptr_q] <= push_last_i;
        wr_ptr_q             <= wr_ptr_q + AW'(1);
      end
      if (rd_en_s) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
      end
      case ({wr_en_s, rd_en_s})
        2'b10:   cnt_q <= cnt_q + CW'(1);
        2'b01:   cnt_q <= cnt_q - CW'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule

// File: rtl/epsilon_conditioner.sv
// Raw entropy conditioner: synchroniser, sample divider, optional von Neumann
// corrector (VN_DEBIAS_EN) and run framing FSM feeding a FWFT output FIFO.
module epsilon_conditioner
  import epsilon_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int DIV_W       = 8,
  parameter int BLOCK_LEN   = 128,
  parameter int FIFO_DEPTH  = 8
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           raw_in,
  input  logic [DIV_W-1:0]               div_ratio,
  input  logic                           start,
  output logic                           eps_dat,
  output logic                           eps_vld,
  input  logic                           eps_rdy,
  output logic                           eps_last,
  output logic                           busy,
  output logic                           done,
  output logic                           overflow,
  output logic [$clog2(BLOCK_LEN+1)-1:0] bit_count
);

  localparam int               CNT_W    = cnt_width(BLOCK_LEN);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLOCK_LEN - 1);

  state_e             state_q;
  logic [SYNC_STAGES-1:0] sync_q;
  logic [DIV_W-1:0]   ratio_q;
  logic [DIV_W-1:0]   div_q;
  logic [DIV_W-1:0]   div_d;
  logic [CNT_W-1:0]   cnt_q;
  logic               ovf_q;
  logic               busy_q;
  logic               done_q;

  logic sample_s;
  logic run_start_s;
  logic tick_s;
  logic emit_s;
  logic emit_bit_s;
  logic push_s;
  logic drop_s;
  logic pop_s;
  logic full_s;
  logic empty_s;
  logic fifo_vld_s;

  always_ff @(posedge clk) begin
    if (rst) sync_q <= '0;
    else     sync_q <= {sync_q[SYNC_STAGES-2:0], raw_in};
  end

  assign sample_s    = sync_q[SYNC_STAGES-1];
  assign run_start_s = (state_q == ST_IDLE) && start;
  assign tick_s      = (state_q == ST_COLLECT) && (div_q == ratio_q);
  assign div_d       = tick_s ? '0 : div_q + DIV_W'(1);

`ifdef VN_DEBIAS_EN
  logic       pair_vld_q;
  logic       pair_s0_q;
  logic [1:0] pair_s;

  always_ff @(posedge clk) begin
    if (rst || run_start_s) begin
      pair_vld_q <= 1'b0;
      pair_s0_q  <= 1'b0;
    end else if (tick_s) begin
      pair_vld_q <= ~pair_vld_q;
      pair_s0_q  <= pair_vld_q ? pair_s0_q : sample_s;
    end
  end

  assign pair_s     = {pair_s0_q, sample_s};
  assign emit_s     = tick_s & pair_vld_q & vn_emits(pair_s);
  assign emit_bit_s = vn_bit(pair_s);
`else
  assign emit_s     = tick_s;
  assign emit_bit_s = sample_s;
`endif

  // A pop frees a slot in the same cycle, so a full FIFO being drained is no drop.
  assign pop_s  = fifo_vld_s & eps_rdy;
  assign push_s = emit_s & (~full_s | pop_s);
  assign drop_s = emit_s & full_s & ~pop_s;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      ratio_q <= '0;
      div_q   <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            state_q <= ST_COLLECT;
            busy_q  <= 1'b1;
            ratio_q <= div_ratio;
            div_q   <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
          end
        end
        ST_COLLECT: begin
          div_q <= div_d;
          if (drop_s) ovf_q <= 1'b1;
          if (push_s) begin
            cnt_q <= cnt_q + CNT_W'(1);
            if (cnt_q == CNT_LAST) state_q <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (empty_s) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  epsilon_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push_i     (push_s),
    .push_dat_i (emit_bit_s),
    .push_last_i(cnt_q == CNT_LAST),
    .pop_i      (pop_s),
    .dat_o      (eps_dat),
    .last_o     (eps_last),
    .vld_o      (fifo_vld_s),
    .full_o     (full_s),
    .empty_o    (empty_s)
  );

  assign eps_vld   = fifo_vld_s;
  assign busy      = busy_q;
  assign done      = done_q;
  assign overflow  = ovf_q;
  assign bit_count = cnt_q;

endmodule
